load_store_unit_l3: RTL and testbench

Execute-stage load/store unit for the word-granular LW/SW path. It accepts a decoded memory micro-op from the decode→execute (D) interface and computes the effective address. It issues a request on the memory interface, tracking up to four outstanding transactions by opaque tag. Each memory response is returned as a writeback message on the execute→writeback (W) interface.

---
 rtl/load_store_unit_l3.sv | 115 +++++++++++
 tb/tb_load_store_unit_l3.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit_l3.sv
// Word LW/SW execute unit: effective address op1+op2, request tagged by tracking-table index, response -> writeback.
// Zero added latency on both paths; D stalls when mem_req_rdy is low or all entries are busy, mem_resp_rdy follows W_rdy.
package load_store_unit_l3_pkg;
    typedef enum logic [3:0] {
        RV_UOP_LW = 4'd2,
        RV_UOP_SW = 4'd3
    } rv_uop;

    localparam logic [2:0] MEM_TYPE_READ  = 3'd0;
    localparam logic [2:0] MEM_TYPE_WRITE = 3'd1;
endpackage

module load_store_unit_l3
    import load_store_unit_l3_pkg::*;
#(
    parameter int p_seq_num_bits = 5,
    parameter int p_opaq_bits    = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      D_val,
    output logic                      D_rdy,
    input  logic [31:0]               D_pc,
    input  logic [p_seq_num_bits-1:0] D_seq_num,
    input  logic [31:0]               D_op1,
    input  logic [31:0]               D_op2,
    input  logic [31:0]               D_op3,
    input  logic [4:0]                D_waddr,
    input  rv_uop                     D_uop,
    input  logic [5:0]                D_preg,
    input  logic [5:0]                D_ppreg,
    output logic                      W_val,
    input  logic                      W_rdy,
    output logic [31:0]               W_pc,
    output logic [p_seq_num_bits-1:0] W_seq_num,
    output logic [4:0]                W_waddr,
    output logic [31:0]               W_wdata,
    output logic                      W_wen,
    output logic                      mem_req_val,
    input  logic                      mem_req_rdy,
    output logic [p_opaq_bits+68:0]   mem_req_msg,
    input  logic                      mem_resp_val,
    output logic                      mem_resp_rdy,
    input  logic [p_opaq_bits+36:0]   mem_resp_msg
);
    localparam int c_n  = (p_opaq_bits >= 2) ? 4 : 2;
    localparam int c_iw = (c_n == 4) ? 2 : 1;

    logic [c_n-1:0]            valid_q, valid_d;
    logic [c_n-1:0]            is_load_q;
    logic [31:0]               pc_q    [c_n];
    logic [p_seq_num_bits-1:0] seq_q   [c_n];
    logic [4:0]                waddr_q [c_n];

    logic                   full, alloc, free, d_is_load, r_is_load;
    logic [c_iw-1:0]        alloc_idx, resp_idx;
    logic [31:0]            req_addr, resp_data;
    logic [p_opaq_bits-1:0] resp_opq;
    logic [2:0]             resp_type;
    logic [1:0]             resp_len;
    logic                   unused_ok;

    // Held in reset the table reads as empty, so D/req pass straight through.
    assign full        = rst && (&valid_q);
    assign D_rdy       = mem_req_rdy && !full;
    assign mem_req_val = D_val && !full;
    assign alloc       = D_val && D_rdy;
    assign d_is_load   = (D_uop == RV_UOP_LW);
    assign req_addr    = D_op1 + D_op2;
    assign mem_req_msg = {d_is_load ? MEM_TYPE_READ : MEM_TYPE_WRITE,
                          p_opaq_bits'(alloc_idx), req_addr, 2'd0,
                          d_is_load ? 32'd0 : D_op3};

    always_comb begin
        alloc_idx = '0;
        for (int i = c_n - 1; i >= 0; i--) begin
            if (!valid_q[i]) alloc_idx = c_iw'(i);
        end
    end

    assign {resp_type, resp_opq, resp_len, resp_data} = mem_resp_msg;
    assign resp_idx     = resp_opq[c_iw-1:0];
    assign r_is_load    = is_load_q[resp_idx];
    assign W_val        = mem_resp_val;
    assign mem_resp_rdy = W_rdy;
    assign free         = mem_resp_val && W_rdy;
    assign W_pc         = pc_q[resp_idx];
    assign W_seq_num    = seq_q[resp_idx];
    assign W_wen        = r_is_load;
    assign W_waddr      = r_is_load ? waddr_q[resp_idx] : 5'd0;
    assign W_wdata      = r_is_load ? resp_data : 32'd0;

    // Alloc only ever targets a free slot, so applying it after the free is safe.
    always_comb begin
        valid_d = valid_q;
        if (free)  valid_d[resp_idx]  = 1'b0;
        if (alloc) valid_d[alloc_idx] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst) valid_q <= '0;
        else      valid_q <= valid_d;
    end

    always_ff @(posedge clk) begin
        if (alloc) begin
            pc_q[alloc_idx]      <= D_pc;
            seq_q[alloc_idx]     <= D_seq_num;
            waddr_q[alloc_idx]   <= D_waddr;
            is_load_q[alloc_idx] <= d_is_load;
        end
    end

    assign unused_ok = ^{D_preg, D_ppreg, resp_type, resp_len, resp_opq};
endmodule

// File: tb/tb_load_store_unit_l3.sv
// Directed bench: instance a has p_opaq_bits=16 (4 entries), instance b has p_opaq_bits=1 (2 entries).
module tb_load_store_unit_l3;
    import load_store_unit_l3_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, mem_req_rdy, W_rdy;
    logic [31:0] d_pc, d_op1, d_op2, d_op3;
    logic [4:0]  d_seq, d_waddr;
    rv_uop       d_uop;
    logic [5:0]  d_preg, d_ppreg;

    logic        a_dval, a_drdy, a_wval, a_wen, a_qval, a_rval, a_rrdy;
    logic [31:0] a_wpc, a_wdata;
    logic [4:0]  a_wseq, a_wwaddr;
    logic [84:0] a_qmsg;
    logic [52:0] a_rmsg;

    logic        b_dval, b_drdy, b_wval, b_wen, b_qval, b_rval, b_rrdy;
    logic [31:0] b_wpc, b_wdata;
    logic [4:0]  b_wseq, b_wwaddr;
    logic [69:0] b_qmsg;
    logic [37:0] b_rmsg;

    int n_asserts = 0;
    int n_fail    = 0;

    load_store_unit_l3 #(.p_seq_num_bits(5), .p_opaq_bits(16)) u_a (
        .clk(clk), .rst(rst), .D_val(a_dval), .D_rdy(a_drdy), .D_pc(d_pc), .D_seq_num(d_seq),
        .D_op1(d_op1), .D_op2(d_op2), .D_op3(d_op3), .D_waddr(d_waddr), .D_uop(d_uop),
        .D_preg(d_preg), .D_ppreg(d_ppreg), .W_val(a_wval), .W_rdy(W_rdy), .W_pc(a_wpc),
        .W_seq_num(a_wseq), .W_waddr(a_wwaddr), .W_wdata(a_wdata), .W_wen(a_wen),
        .mem_req_val(a_qval), .mem_req_rdy(mem_req_rdy), .mem_req_msg(a_qmsg),
        .mem_resp_val(a_rval), .mem_resp_rdy(a_rrdy), .mem_resp_msg(a_rmsg)
    );

    load_store_unit_l3 #(.p_seq_num_bits(5), .p_opaq_bits(1)) u_b (
        .clk(clk), .rst(rst), .D_val(b_dval), .D_rdy(b_drdy), .D_pc(d_pc), .D_seq_num(d_seq),
        .D_op1(d_op1), .D_op2(d_op2), .D_op3(d_op3), .D_waddr(d_waddr), .D_uop(d_uop),
        .D_preg(d_preg), .D_ppreg(d_ppreg), .W_val(b_wval), .W_rdy(W_rdy), .W_pc(b_wpc),
        .W_seq_num(b_wseq), .W_waddr(b_wwaddr), .W_wdata(b_wdata), .W_wen(b_wen),
        .mem_req_val(b_qval), .mem_req_rdy(mem_req_rdy), .mem_req_msg(b_qmsg),
        .mem_resp_val(b_rval), .mem_resp_rdy(b_rrdy), .mem_resp_msg(b_rmsg)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        a_dval = 1'b0; b_dval = 1'b0; a_rval = 1'b0; b_rval = 1'b0;
    endtask

    task automatic drv_d(input bit sb, input rv_uop u, input logic [31:0] pc, input int seq,
                         input logic [31:0] op1, input logic [31:0] op2, input logic [31:0] op3,
                         input int waddr);
        d_uop = u; d_pc = pc; d_seq = 5'(seq); d_op1 = op1; d_op2 = op2; d_op3 = op3;
        d_waddr = 5'(waddr); d_preg = 'x; d_ppreg = 'x;
        if (sb) b_dval = 1'b1;
        else    a_dval = 1'b1;
    endtask

    task automatic drv_r(input bit sb, input int opq, input logic [2:0] ty, input logic [31:0] data);
        if (sb) begin
            b_rval = 1'b1; b_rmsg = {ty, opq[0], 2'b00, data};
        end else begin
            a_rval = 1'b1; a_rmsg = {ty, 16'(opq), 2'b00, data};
        end
    endtask

    task automatic chk_req(input string s, input bit sb, input bit ev, input bit er, input int opq,
                           input logic [2:0] ty, input logic [31:0] addr, input logic [31:0] data);
        chk({s, ".d_rdy"}, 32'(sb ? b_drdy : a_drdy), 32'(er));
        chk({s, ".req_val"}, 32'(sb ? b_qval : a_qval), 32'(ev));
        if (ev) begin
            chk({s, ".opaque"}, sb ? 32'(b_qmsg[66]) : 32'(a_qmsg[81:66]), 32'(opq));
            chk({s, ".type"}, sb ? 32'(b_qmsg[69:67]) : 32'(a_qmsg[84:82]), 32'(ty));
            chk({s, ".addr"}, sb ? b_qmsg[65:34] : a_qmsg[65:34], addr);
            chk({s, ".len"}, sb ? 32'(b_qmsg[33:32]) : 32'(a_qmsg[33:32]), 32'd0);
            chk({s, ".data"}, sb ? b_qmsg[31:0] : a_qmsg[31:0], data);
        end
    endtask

    task automatic chk_w(input string s, input bit sb, input logic [31:0] pc, input int seq,
                         input int waddr, input logic [31:0] wdata, input bit wen);
        chk({s, ".w_val"}, 32'(sb ? b_wval : a_wval), 32'd1);
        chk({s, ".w_pc"}, sb ? b_wpc : a_wpc, pc);
        chk({s, ".w_seq"}, 32'(sb ? b_wseq : a_wseq), 32'(seq & 31));
        chk({s, ".w_waddr"}, 32'(sb ? b_wwaddr : a_wwaddr), 32'(waddr));
        chk({s, ".w_wdata"}, sb ? b_wdata : a_wdata, wdata);
        chk({s, ".w_wen"}, 32'(sb ? b_wen : a_wen), 32'(wen));
    endtask

    // Back-to-back load i: pc 0x300+4i, seq 10+i, addr 0x2000+4i, waddr 8+i, memory word 0xA0000000+i.
    task automatic drv_lw(input int i);
        drv_d(0, RV_UOP_LW, 32'h300 + 32'(4 * i), 10 + i, 32'h2000, 32'(4 * i), 32'h0, 8 + i);
    endtask

    task automatic chk_wlw(input string s, input int i);
        chk_w(s, 0, 32'h300 + 32'(4 * i), 10 + i, 8 + i, 32'hA000_0000 + 32'(i), 1'b1);
    endtask

    initial begin
        rst = 1'b0; mem_req_rdy = 1'b1; W_rdy = 1'b0;
        a_rmsg = '0; b_rmsg = '0;
        idle();
        drv_d(0, RV_UOP_LW, 32'h0, 0, 32'h0, 32'h0, 32'h0, 0);
        a_rval = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        chk("rst.d_rdy", 32'(a_drdy), 32'd1);
        chk("rst.req_val", 32'(a_qval), 32'd1);
        chk("rst.w_val", 32'(a_wval), 32'd1);
        chk("rst.resp_rdy", 32'(a_rrdy), 32'd0);
        chk("rst.b_req_val", 32'(b_qval), 32'd0);
        mem_req_rdy = 1'b0; #1;
        chk("rst.d_rdy_follows", 32'(a_drdy), 32'd0);
        chk("rst.req_val_follows", 32'(a_qval), 32'd1);
        idle(); mem_req_rdy = 1'b1; W_rdy = 1'b1; rst = 1'b1;

        // Single LW, SW, LW-after-SW, address wrap
        @(negedge clk); idle(); drv_d(0, RV_UOP_LW, 32'h200, 1, 32'h1000, 32'h4, 32'h0, 3); #1;
        chk_req("lw1", 0, 1, 1, 0, MEM_TYPE_READ, 32'h1004, 32'h0);
        @(negedge clk); idle(); drv_r(0, 0, MEM_TYPE_READ, 32'hDEAD_BEEF); #1;
        chk_w("lw1", 0, 32'h200, 1, 3, 32'hDEAD_BEEF, 1'b1);
        @(negedge clk); idle(); drv_d(0, RV_UOP_SW, 32'h204, 2, 32'h1000, 32'h8, 32'h1234_5678, 5); #1;
        chk_req("sw1", 0, 1, 1, 0, MEM_TYPE_WRITE, 32'h1008, 32'h1234_5678);
        @(negedge clk); idle(); drv_r(0, 0, MEM_TYPE_WRITE, 32'h0); #1;
        chk_w("sw1", 0, 32'h204, 2, 0, 32'h0, 1'b0);
        @(negedge clk); idle(); drv_d(0, RV_UOP_LW, 32'h208, 3, 32'h1000, 32'h8, 32'h0, 7); #1;
        chk_req("lw2", 0, 1, 1, 0, MEM_TYPE_READ, 32'h1008, 32'h0);
        @(negedge clk); idle(); drv_r(0, 0, MEM_TYPE_READ, 32'h1234_5678); #1;
        chk_w("lw2", 0, 32'h208, 3, 7, 32'h1234_5678, 1'b1);
        @(negedge clk); idle(); drv_d(0, RV_UOP_LW, 32'h20C, 4, 32'hFFFF_FFFC, 32'h8, 32'h0, 1); #1;
        chk_req("wrap", 0, 1, 1, 0, MEM_TYPE_READ, 32'h4, 32'h0);
        @(negedge clk); idle(); drv_r(0, 0, MEM_TYPE_READ, 32'hCAFE_F00D); #1;
        chk_w("wrap", 0, 32'h20C, 4, 1, 32'hCAFE_F00D, 1'b1);

        // Six back-to-back loads, responses four cycles after acceptance
        @(negedge clk); idle(); drv_lw(0); #1; chk_req("b2b0", 0, 1, 1, 0, MEM_TYPE_READ, 32'h2000, 32'h0);
        @(negedge clk); idle(); drv_lw(1); #1; chk_req("b2b1", 0, 1, 1, 1, MEM_TYPE_READ, 32'h2004, 32'h0);
        @(negedge clk); idle(); drv_lw(2); #1; chk_req("b2b2", 0, 1, 1, 2, MEM_TYPE_READ, 32'h2008, 32'h0);
        @(negedge clk); idle(); drv_lw(3); #1; chk_req("b2b3", 0, 1, 1, 3, MEM_TYPE_READ, 32'h200C, 32'h0);
        @(negedge clk); idle(); drv_lw(4); drv_r(0, 0, MEM_TYPE_READ, 32'hA000_0000); #1;
        chk_req("b2b_full", 0, 0, 0, 0, MEM_TYPE_READ, 32'h0, 32'h0); chk_wlw("b2b_w0", 0);
        @(negedge clk); idle(); drv_lw(4); drv_r(0, 1, MEM_TYPE_READ, 32'hA000_0001); #1;
        chk_req("b2b4", 0, 1, 1, 0, MEM_TYPE_READ, 32'h2010, 32'h0); chk_wlw("b2b_w1", 1);
        @(negedge clk); idle(); drv_lw(5); drv_r(0, 2, MEM_TYPE_READ, 32'hA000_0002); #1;
        chk_req("b2b5", 0, 1, 1, 1, MEM_TYPE_READ, 32'h2014, 32'h0); chk_wlw("b2b_w2", 2);
        @(negedge clk); idle(); drv_r(0, 3, MEM_TYPE_READ, 32'hA000_0003); #1;
        chk_req("b2b_idle", 0, 0, 1, 0, MEM_TYPE_READ, 32'h0, 32'h0); chk_wlw("b2b_w3", 3);
        @(negedge clk); idle();
        @(negedge clk); idle(); drv_r(0, 0, MEM_TYPE_READ, 32'hA000_0004); #1; chk_wlw("b2b_w4", 4);
        @(negedge clk); idle(); drv_r(0, 1, MEM_TYPE_READ, 32'hA000_0005); #1; chk_wlw("b2b_w5", 5);

        // Writeback backpressure holds the entry until the handshake
        @(negedge clk); idle(); drv_d(0, RV_UOP_LW, 32'h400, 20, 32'h3000, 32'h0, 32'h0, 9); #1;
        chk_req("bp_lw", 0, 1, 1, 0, MEM_TYPE_READ, 32'h3000, 32'h0);
        W_rdy = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); idle(); drv_r(0, 0, MEM_TYPE_READ, 32'h55AA_55AA); #1;
            chk("bp.resp_rdy", 32'(a_rrdy), 32'd0);
            chk_w("bp_hold", 0, 32'h400, 20, 9, 32'h55AA_55AA, 1'b1);
        end
        @(negedge clk); idle(); drv_r(0, 0, MEM_TYPE_READ, 32'h55AA_55AA);
        drv_d(0, RV_UOP_LW, 32'h404, 21, 32'h3000, 32'h4, 32'h0, 10); #1;
        chk_req("bp_held_slot", 0, 1, 1, 1, MEM_TYPE_READ, 32'h3004, 32'h0);
        @(negedge clk); idle(); W_rdy = 1'b1; drv_r(0, 0, MEM_TYPE_READ, 32'h55AA_55AA); #1;
        chk("bp.resp_rdy_hs", 32'(a_rrdy), 32'd1);
        chk_w("bp_hs", 0, 32'h400, 20, 9, 32'h55AA_55AA, 1'b1);
        @(negedge clk); idle(); drv_d(0, RV_UOP_LW, 32'h408, 22, 32'h3000, 32'h8, 32'h0, 11); #1;
        chk_req("bp_reuse", 0, 1, 1, 0, MEM_TYPE_READ, 32'h3008, 32'h0);
        @(negedge clk); idle(); drv_r(0, 0, MEM_TYPE_READ, 32'h0BAD_F00D); #1;
        chk_w("ooo_first", 0, 32'h408, 22, 11, 32'h0BAD_F00D, 1'b1);
        @(negedge clk); idle(); drv_r(0, 1, MEM_TYPE_READ, 32'h1357_9BDF); #1;
        chk_w("ooo_second", 0, 32'h404, 21, 10, 32'h1357_9BDF, 1'b1);

        // Two-entry instance: interleaved store/load stream
        @(negedge clk); idle(); drv_d(1, RV_UOP_SW, 32'h500, 1, 32'h40, 32'h0, 32'h1111_1111, 1); #1;
        chk_req("n2_swA", 1, 1, 1, 0, MEM_TYPE_WRITE, 32'h40, 32'h1111_1111);
        @(negedge clk); idle(); drv_d(1, RV_UOP_LW, 32'h504, 2, 32'h40, 32'h0, 32'h0, 4); #1;
        chk_req("n2_lwA", 1, 1, 1, 1, MEM_TYPE_READ, 32'h40, 32'h0);
        @(negedge clk); idle(); drv_d(1, RV_UOP_SW, 32'h508, 3, 32'h44, 32'h0, 32'h2222_2222, 2);
        drv_r(1, 0, MEM_TYPE_WRITE, 32'h0); #1;
        chk_req("n2_full", 1, 0, 0, 0, MEM_TYPE_WRITE, 32'h0, 32'h0);
        chk_w("n2_w_swA", 1, 32'h500, 1, 0, 32'h0, 1'b0);
        @(negedge clk); idle(); drv_d(1, RV_UOP_SW, 32'h508, 3, 32'h44, 32'h0, 32'h2222_2222, 2);
        drv_r(1, 1, MEM_TYPE_READ, 32'h1111_1111); #1;
        chk_req("n2_swB", 1, 1, 1, 0, MEM_TYPE_WRITE, 32'h44, 32'h2222_2222);
        chk_w("n2_w_lwA", 1, 32'h504, 2, 4, 32'h1111_1111, 1'b1);
        @(negedge clk); idle(); drv_d(1, RV_UOP_LW, 32'h50C, 4, 32'h44, 32'h0, 32'h0, 5); #1;
        chk_req("n2_lwB", 1, 1, 1, 1, MEM_TYPE_READ, 32'h44, 32'h0);
        @(negedge clk); idle(); drv_r(1, 0, MEM_TYPE_WRITE, 32'h0); #1;
        chk_w("n2_w_swB", 1, 32'h508, 3, 0, 32'h0, 1'b0);
        @(negedge clk); idle(); drv_r(1, 1, MEM_TYPE_READ, 32'h2222_2222); #1;
        chk_w("n2_w_lwB", 1, 32'h50C, 4, 5, 32'h2222_2222, 1'b1);

        @(negedge clk); idle();
        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end
endmodule
